fifo_push_arbiter: RTL

Round-robin arbiter that shares the single push port of an inter-stage `FIFO` among `NUM_REQ` producers, such as the fetch, replay and exception-redirect paths. It registers the winning element and drives the FIFO's `pushing`/`in_data`. On backpressure from `push_must_wait` it holds that element stable until the FIFO accepts it. A flush input discards any held element.

---
 rtl/fifo_push_arbiter_pkg.sv | 21 ++
 rtl/fifo_push_arbiter_if.sv | 55 +++++
 rtl/fifo_push_arbiter_rr_pick.sv | 49 ++++
 rtl/fifo_push_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and default sizes for the FIFO push-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: arb_state_e (IDLE/PUSH/HOLD), default requester count,
// element width and statistics counter width.
package fifo_arb_pkg;

  localparam int FIFO_ARB_NUM_REQ   = 4;
  localparam int FIFO_ARB_ELEM_BITS = 96;
  localparam int FIFO_ARB_CNT_BITS  = 32;

  // IDLE: nothing on the FIFO push port.
  // PUSH: freshly granted element presented for the first time.
  // HOLD: element refused last cycle, presented again unchanged.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_e;

endpackage : fifo_arb_pkg

// File: rtl/fifo_push_arbiter_if.sv
// Bundle of requester, FIFO push-port and statistics signals for the arbiter.
// Latency: n/a (wires only).
// Backpressure: fifo_push_must_wait from the FIFO, req_ready back to requesters.
// Ports:
//   master (arbiter side): drives req_ready, fifo_pushing, fifo_in_data,
//     grant_id, stall_cycles, grant_count; samples req_valid, req_data,
//     flush, fifo_push_must_wait.
//   slave (environment side): the mirror image.
interface fifo_push_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ        = FIFO_ARB_NUM_REQ,
  parameter int ELEM_SIZE_BITS = FIFO_ARB_ELEM_BITS
) ();

  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ*ELEM_SIZE_BITS-1:0]    req_data;
  logic [NUM_REQ-1:0]                   req_ready;
  logic                                 flush;
  logic                                 fifo_pushing;
  logic [ELEM_SIZE_BITS-1:0]            fifo_in_data;
  logic                                 fifo_push_must_wait;
  logic [IDW-1:0]                       grant_id;
  logic [FIFO_ARB_CNT_BITS-1:0]         stall_cycles;
  logic [NUM_REQ*FIFO_ARB_CNT_BITS-1:0] grant_count;

  modport master (
    input  req_valid,
    input  req_data,
    output req_ready,
    input  flush,
    output fifo_pushing,
    output fifo_in_data,
    input  fifo_push_must_wait,
    output grant_id,
    output stall_cycles,
    output grant_count
  );

  modport slave (
    output req_valid,
    output req_data,
    input  req_ready,
    output flush,
    input  fifo_pushing,
    input  fifo_in_data,
    output fifo_push_must_wait,
    input  grant_id,
    input  stall_cycles,
    input  grant_count
  );

endinterface : fifo_push_arbiter_if

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
// Ports: req (request vector), ptr (search start), gnt (one-hot pick),
//   gnt_idx (index of pick), any (at least one request present).
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = FIFO_ARB_NUM_REQ
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // One extra bit so ptr + offset never overflows before the modulo fold;
  // ptr + offset <= 2N-2 < 2^(IW+1).
  logic [IW:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid requester
  // (smallest offset from ptr) is the last, and therefore winning, assignment.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (req[cand[IW-1:0]]) begin
        gnt_idx = cand[IW-1:0];
        any     = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule : rr_pick

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ producers.
// Latency: element granted in cycle N is on fifo_in_data/fifo_pushing in N+1.
// Backpressure: fifo_push_must_wait holds the element stable (HOLD); no grants until accepted.
// Ports: CLK, RESET (synchronous, active-low), bus (fifo_push_arbiter_if.master).
// Optional: define FIFO_ARB_STATS_EN to build the stall_cycles / grant_count
//   saturating counters; otherwise those outputs are tied to zero.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ        = FIFO_ARB_NUM_REQ,
  parameter int ELEM_SIZE_BITS = FIFO_ARB_ELEM_BITS
) (
  input logic                 CLK,
  input logic                 RESET,
  fifo_push_arbiter_if.master bus
);

  localparam int IDW = $clog2(NUM_REQ);

  arb_state_e                state_q,  state_d;
  logic [IDW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]            gid_q,    gid_d;
  logic [ELEM_SIZE_BITS-1:0] data_q,   data_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic               slot_free;
  logic               grant;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // The output register can take a new element when it is empty or when the
  // FIFO is consuming the current one this very cycle (back-to-back pushes).
  assign slot_free = (state_q == ST_IDLE) || !bus.fifo_push_must_wait;
  assign grant     = slot_free && !bus.flush && RESET && pick_any;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gid_d         = gid_q;
    data_d        = data_q;
    bus.req_ready = '0;
    if (bus.flush) begin
      // Drop whatever is held; pointer kept so fairness survives the flush.
      state_d = ST_IDLE;
    end else if (grant) begin
      bus.req_ready = pick_gnt;
      data_d        = bus.req_data[int'(pick_idx)*ELEM_SIZE_BITS +: ELEM_SIZE_BITS];
      gid_d         = pick_idx;
      rr_ptr_d      = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDW'(1);
      state_d       = ST_PUSH;
    end else if (slot_free) begin
      state_d = ST_IDLE;
    end else begin
      state_d = ST_HOLD;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      data_q   <= data_d;
    end
  end

  assign bus.fifo_pushing = (state_q != ST_IDLE);
  assign bus.fifo_in_data = data_q;
  assign bus.grant_id     = gid_q;

`ifdef FIFO_ARB_STATS_EN
  logic                         accepted;
  logic [FIFO_ARB_CNT_BITS-1:0] stall_q, stall_d;
  logic [FIFO_ARB_CNT_BITS-1:0] gcnt_q [NUM_REQ];
  logic [FIFO_ARB_CNT_BITS-1:0] gcnt_d [NUM_REQ];

  // Acceptance is independent of flush: a same-cycle flush cannot un-push
  // an element the FIFO has already taken.
  assign accepted = (state_q != ST_IDLE) && !bus.fifo_push_must_wait;

  always_comb begin
    stall_d = stall_q;
    gcnt_d  = gcnt_q;
    if ((state_q == ST_HOLD) && (stall_q != '1)) begin
      stall_d = stall_q + FIFO_ARB_CNT_BITS'(1);
    end
    if (accepted && (gcnt_q[gid_q] != '1)) begin
      gcnt_d[gid_q] = gcnt_q[gid_q] + FIFO_ARB_CNT_BITS'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      stall_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        gcnt_q[i] <= '0;
      end
    end else begin
      stall_q <= stall_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign bus.stall_cycles = stall_q;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_pack
    assign bus.grant_count[g*FIFO_ARB_CNT_BITS +: FIFO_ARB_CNT_BITS] = gcnt_q[g];
  end
`else
  assign bus.stall_cycles = '0;
  assign bus.grant_count  = '0;
`endif

endmodule : fifo_push_arbiter
